nbody_sweep_sched: RTL and testbench



---
 rtl/nbody_pkg.sv | 21 ++
 rtl/nbody_sweep_sched_tag_delay.sv | 55 +++++
 rtl/nbody_sweep_sched.sv | 207 ++++++++++++++++++++
 tb/tb_nbody_sweep_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbody_pkg.sv
// Shared constants and types for the n-body sweep scheduler.
// Latency figures describe the getAccl and AddSub pipelines it drives.
package nbody_pkg;

  localparam int ADD_LATENCY     = 20;
  localparam int MULT_LATENCY    = 11;
  localparam int INVSQRT_LATENCY = 32;
  localparam int ACCL_LATENCY    = 123;
  localparam int RAM_LAT         = 1;
  localparam int MIN_BODIES      = ADD_LATENCY + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_ACCEL_DRAIN,
    S_POS,
    S_POS_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/nbody_sweep_sched_tag_delay.sv
// tag_delay: DEPTH-stage {valid,data} shift line, sync flush, any_valid.
// Ports: clk, rst, flush, in_valid/in_data, out_valid/out_data, any_valid.
module tag_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];

  // Invalid slots carry zero data so addresses idle at 0.
  always_comb begin
    vld_d[0] = in_valid;
    dat_d[0] = in_valid ? in_data : '0;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = dat_q[k-1];
    end
    if (flush) begin
      vld_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < DEPTH; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/nbody_sweep_sched.sv
// nbody_sweep_sched: pair/position sweep sequencer with tagged RAM strobes.
// Ports: start/abort/done_ack, num_bodies/steps in; status, pair, RAM strobes out.
module nbody_sweep_sched
  import nbody_pkg::*;
#(
  parameter int BODIES = 512,
  parameter int BAW    = $clog2(BODIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           done_ack,
  input  logic [BAW:0]   num_bodies,
  input  logic [15:0]    steps,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           first_step,
  output logic [BAW-1:0] p_i,
  output logic [BAW-1:0] p_j,
  output logic           p_valid,
  output logic [BAW-1:0] v_rd_addr,
  output logic           v_rd_en,
  output logic [BAW-1:0] v_wr_addr,
  output logic           v_wr_en,
  output logic [BAW-1:0] pos_rd_addr,
  output logic [BAW-1:0] pos_wr_addr,
  output logic           pos_wr_en
);

  localparam int VRD_DEPTH = ACCL_LATENCY - RAM_LAT;
  localparam int VWR_DEPTH = ACCL_LATENCY + ADD_LATENCY;
  localparam int POS_DEPTH = RAM_LAT + ADD_LATENCY;
  localparam logic [BAW:0] MIN_N = (BAW+1)'(MIN_BODIES);
  localparam logic [BAW:0] MAX_N = (BAW+1)'(BODIES);

  sched_state_t state_q, state_d;
  logic [BAW:0]   n_q, n_d;
  logic [15:0]    steps_q, steps_d;
  logic [15:0]    step_q, step_d;
  logic [BAW-1:0] i_q, i_d;
  logic [BAW-1:0] j_q, j_d;
  logic [BAW-1:0] k_q, k_d;
  logic           first_q, first_d;
  logic           err_q, err_d;
  logic           flush;
  logic           vrd_any, vwr_any, pos_any;
  logic           pos_issue;
  logic [BAW:0]   nm1;
  logic           n_ok;

  assign nm1  = n_q - (BAW+1)'(1);
  assign n_ok = (num_bodies >= MIN_N) && (num_bodies <= MAX_N);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    steps_d = steps_q;
    step_d  = step_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    first_d = first_q;
    err_d   = 1'b0;
    flush   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      flush   = 1'b1;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      step_d  = '0;
      first_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (n_ok) begin
              n_d     = num_bodies;
              steps_d = (steps == 16'd0) ? 16'd1 : steps;
              step_d  = '0;
              first_d = 1'b1;
              i_d     = '0;
              j_d     = '0;
              state_d = S_ACCEL;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_ACCEL: begin
          if ({1'b0, j_q} == nm1) begin
            j_d = '0;
            if ({1'b0, i_q} == nm1) begin
              i_d     = '0;
              state_d = S_ACCEL_DRAIN;
            end else begin
              i_d = i_q + BAW'(1);
            end
          end else begin
            j_d = j_q + BAW'(1);
          end
        end
        S_ACCEL_DRAIN: begin
          if (!vrd_any && !vwr_any) begin
            state_d = S_POS;
          end
        end
        S_POS: begin
          if ({1'b0, k_q} == nm1) begin
            k_d     = '0;
            state_d = S_POS_DRAIN;
          end else begin
            k_d = k_q + BAW'(1);
          end
        end
        S_POS_DRAIN: begin
          if (!pos_any) begin
            first_d = 1'b0;
            if (step_q == steps_q - 16'd1) begin
              state_d = S_DONE;
            end else begin
              step_d  = step_q + 16'd1;
              state_d = S_ACCEL;
            end
          end
        end
        S_DONE: begin
          if (done_ack) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      steps_q <= '0;
      step_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      steps_q <= steps_d;
      step_q  <= step_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign first_step  = first_q;
  assign p_valid     = (state_q == S_ACCEL);
  assign p_i         = i_q;
  assign p_j         = j_q;
  assign pos_issue   = (state_q == S_POS);
  assign pos_rd_addr = k_q;

  // Only j rides along: the velocity RAM is indexed by target body.
  tag_delay #(.DEPTH(VRD_DEPTH), .WIDTH(BAW)) u_vrd (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (p_valid),
    .in_data  (j_q),
    .out_valid(v_rd_en),
    .out_data (v_rd_addr),
    .any_valid(vrd_any)
  );

  tag_delay #(.DEPTH(VWR_DEPTH), .WIDTH(BAW)) u_vwr (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (p_valid),
    .in_data  (j_q),
    .out_valid(v_wr_en),
    .out_data (v_wr_addr),
    .any_valid(vwr_any)
  );

  tag_delay #(.DEPTH(POS_DEPTH), .WIDTH(BAW)) u_pos (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (pos_issue),
    .in_data  (k_q),
    .out_valid(pos_wr_en),
    .out_data (pos_wr_addr),
    .any_valid(pos_any)
  );

endmodule

// File: tb/tb_nbody_sweep_sched.sv
// Scoreboard bench for nbody_sweep_sched: model queues vs. monitored strobes.
// Covers reject, normal runs, multi-step, abort, done/ack, reset mid-POS.
module tb_nbody_sweep_sched;
  import nbody_pkg::*;

  localparam int NB  = 512;
  localparam int BW  = 9;
  localparam int VRD = ACCL_LATENCY - RAM_LAT;
  localparam int VWR = ACCL_LATENCY + ADD_LATENCY;
  localparam int PWR = RAM_LAT + ADD_LATENCY;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, done_ack;
  logic [BW:0]   num_bodies;
  logic [15:0]   steps;
  logic          busy, done, err, first_step;
  logic [BW-1:0] p_i, p_j, v_rd_addr, v_wr_addr;
  logic [BW-1:0] pos_rd_addr, pos_wr_addr;
  logic          p_valid, v_rd_en, v_wr_en, pos_wr_en;

  nbody_sweep_sched #(.BODIES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .done_ack   (done_ack),
    .num_bodies (num_bodies),
    .steps      (steps),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .first_step (first_step),
    .p_i        (p_i),
    .p_j        (p_j),
    .p_valid    (p_valid),
    .v_rd_addr  (v_rd_addr),
    .v_rd_en    (v_rd_en),
    .v_wr_addr  (v_wr_addr),
    .v_wr_en    (v_wr_en),
    .pos_rd_addr(pos_rd_addr),
    .pos_wr_addr(pos_wr_addr),
    .pos_wr_en  (pos_wr_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int q_pair[$];
  int q_vrd[$];
  int q_vwr[$];
  int q_pos[$];
  int t_rd[$];
  int t_wr[$];
  int run_n = 1;
  int pairs_seen = 0;
  int vwr_seen = 0;
  int pos_seen = 0;
  int pos_hist[64];
  int e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the model queues whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (!rst) begin
      pos_hist[cyc % 64] = int'(pos_rd_addr);
      if (p_valid) begin
        chk("pair_pending", int'(q_pair.size() > 0), 1);
        if (q_pair.size() > 0) begin
          e = q_pair.pop_front();
          chk("pair_i", int'(p_i), e >> 16);
          chk("pair_j", int'(p_j), e & 16'hffff);
          chk("first_step_accel", int'(first_step),
              int'(pairs_seen < run_n * run_n));
          chk("order_pair_after_pos", pos_seen,
              run_n * (pairs_seen / (run_n * run_n)));
          pairs_seen++;
          t_rd.push_back(cyc);
          t_wr.push_back(cyc);
        end
      end
      if (v_rd_en) begin
        chk("vrd_pending", int'(q_vrd.size() > 0 && t_rd.size() > 0), 1);
        if (q_vrd.size() > 0 && t_rd.size() > 0) begin
          chk("vrd_addr", int'(v_rd_addr), q_vrd.pop_front());
          chk("vrd_latency", cyc - t_rd.pop_front(), VRD);
        end
      end
      if (v_wr_en) begin
        chk("vwr_pending", int'(q_vwr.size() > 0 && t_wr.size() > 0), 1);
        if (q_vwr.size() > 0 && t_wr.size() > 0) begin
          chk("vwr_addr", int'(v_wr_addr), q_vwr.pop_front());
          chk("vwr_latency", cyc - t_wr.pop_front(), VWR);
          vwr_seen++;
        end
      end
      if (pos_wr_en) begin
        chk("pos_pending", int'(q_pos.size() > 0), 1);
        if (q_pos.size() > 0) begin
          chk("pos_wr_addr", int'(pos_wr_addr), q_pos.pop_front());
          chk("pos_rd_to_wr", pos_hist[(cyc + 64 - PWR) % 64],
              int'(pos_wr_addr));
          chk("first_step_pos", int'(first_step),
              int'(pos_seen < run_n));
          chk("order_pos_after_vwr", vwr_seen,
              run_n * run_n * (pos_seen / run_n + 1));
          pos_seen++;
        end
      end
    end
  end

  task automatic tick(int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q_pair.delete();
    q_vrd.delete();
    q_vwr.delete();
    q_pos.delete();
    t_rd.delete();
    t_wr.delete();
    pairs_seen = 0;
    vwr_seen = 0;
    pos_seen = 0;
  endtask

  // Reference: all-pairs sweep (i outer, j inner) then positions, per step.
  task automatic launch(int n, int s);
    int se;
    se = (s == 0) ? 1 : s;
    if (n >= MIN_BODIES && n <= NB) begin
      clear_model();
      run_n = n;
      for (int st = 0; st < se; st++) begin
        for (int i = 0; i < n; i++) begin
          for (int j = 0; j < n; j++) begin
            q_pair.push_back((i << 16) | j);
            q_vrd.push_back(j);
            q_vwr.push_back(j);
          end
        end
        for (int k = 0; k < n; k++) q_pos.push_back(k);
      end
    end
    num_bodies = (BW+1)'(n);
    steps = 16'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, string nm);
    int c;
    c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    chk(nm, int'(done), 1);
  endtask

  task automatic end_checks(int n, int s);
    int se;
    se = (s == 0) ? 1 : s;
    chk("pairs_total", pairs_seen, n * n * se);
    chk("vwr_total", vwr_seen, n * n * se);
    chk("pos_total", pos_seen, n * se);
    chk("pair_q_left", q_pair.size(), 0);
    chk("vrd_q_left", q_vrd.size(), 0);
    chk("busy_in_done", int'(busy), 0);
  endtask

  task automatic ack();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("done_after_ack", int'(done), 0);
    chk("busy_after_ack", int'(busy), 0);
  endtask

  task automatic reject(int n);
    int errs, bsy;
    errs = 0;
    bsy = 0;
    launch(n, 1);
    for (int c = 0; c < 4; c++) begin
      errs += int'(err);
      bsy |= int'(busy);
      tick();
    end
    chk("err_pulse_count", errs, 1);
    chk("busy_on_reject", bsy, 0);
  endtask

  function automatic int outs_or();
    return int'({busy, done, err, first_step, p_valid,
                 v_rd_en, v_wr_en, pos_wr_en}) |
           int'(p_i) | int'(p_j) | int'(v_rd_addr) | int'(v_wr_addr) |
           int'(pos_rd_addr) | int'(pos_wr_addr);
  endfunction

  initial begin
    int n, s, en_cnt, c;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    done_ack = 1'b0;
    num_bodies = '0;
    steps = '0;
    tick(3);
    chk("reset_outputs", outs_or(), 0);
    rst = 1'b0;
    tick(2);

    reject(20);
    reject(513);
    reject(0);

    // n=21, one step, then a held-off ack with a stray start in DONE.
    launch(21, 1);
    wait_done(1500, "done_n21_s1");
    end_checks(21, 1);
    for (int c2 = 0; c2 < 10; c2++) begin
      if (c2 == 4) begin
        num_bodies = 10'd21;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("done_held", int'(done), 1);
    end
    chk("start_in_done_busy", int'(busy), 0);
    ack();

    launch(21, 3);
    wait_done(3000, "done_n21_s3");
    end_checks(21, 3);
    ack();

    // Abort 50 cycles into ACCEL, with a simultaneous start.
    launch(21, 2);
    tick(50);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    clear_model();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    en_cnt = 0;
    for (int c2 = 0; c2 < 200; c2++) begin
      en_cnt += int'(p_valid) + int'(v_wr_en) + int'(pos_wr_en) +
                int'(v_rd_en);
      tick();
    end
    chk("abort_quiet", en_cnt, 0);

    // Largest legal count: sweep past the j wrap, then abort.
    launch(NB, 1);
    tick(600);
    chk("n512_busy", int'(busy), 1);
    chk("n512_pairs", int'(pairs_seen >= NB), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    clear_model();
    tick(200);
    chk("n512_abort_idle", int'(busy), 0);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(40, 21);
      s = $urandom_range(2, 0);
      launch(n, s);
      wait_done(2 * (n * n + n + 250) + 100, "done_random");
      end_checks(n, s);
      ack();
    end

    // Reset during POS, then a fresh run.
    launch(21, 1);
    c = 0;
    while (vwr_seen < 441 && c < 1500) begin
      tick();
      c++;
    end
    chk("reach_pos", vwr_seen, 441);
    tick(10);
    rst = 1'b1;
    #1;
    chk("rst_mid_pos_outputs", outs_or(), 0);
    clear_model();
    tick(2);
    rst = 1'b0;
    tick(2);
    launch(21, 1);
    wait_done(1500, "done_after_rst");
    end_checks(21, 1);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
